btn_pulser: RTL



---
 rtl/btn_pulser_pkg.sv | 24 ++
 rtl/btn_pulser_if.sv | 20 ++
 rtl/btn_pulser_sync2.sv | 37 +++
 rtl/btn_pulser.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pulser_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the pushbutton conditioner and other front-panel
// logic (the display multiplexer refresh reuses msToCycles).
//   - 3-bit FSM state encodings for btn_pulser
//   - msToCycles: converts a millisecond interval into clock cycles,
//     clamped to at least one cycle so very slow clocks still behave
// ---------------------------------------------------------------------------
package btn_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_PRESSED      = 3'd2;
  localparam logic [2:0] ST_REPEAT       = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

  // Divide first so large clock rates cannot overflow a 32-bit int.
  function automatic int msToCycles(input int freqHz, input int ms);
    int cyc;
    cyc = (freqHz / 1000) * ms;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/btn_pulser_if.sv
// ---------------------------------------------------------------------------
// btn_pulser_if
// Bundles one button's raw pin and its conditioned outputs.
//   i_button  raw asynchronous pin (driven by the board/master side)
//   o_level   debounced pressed level, 1 = pressed
//   o_pulse   one-cycle strobe for press and auto-repeat events
//   o_repeat  high while the auto-repeat phase is active
// Modports: master = pin source / event consumer, slave = btn_pulser.
// ---------------------------------------------------------------------------
interface btn_pulser_if;

  logic i_button;
  logic o_level;
  logic o_pulse;
  logic o_repeat;

  modport master (output i_button, input o_level, input o_pulse, input o_repeat);
  modport slave  (input i_button, output o_level, output o_pulse, output o_repeat);

endinterface

// File: rtl/btn_pulser_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for any asynchronous input pin.
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronised output (two cycles of latency)
// RESET_VAL sets what both flops hold during reset, normally the idle level
// of the pin so that reset release never looks like an input event.
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle
  // before anything downstream looks at the value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/btn_pulser.sv
// ---------------------------------------------------------------------------
// btn_pulser
// Conditions one raw pushbutton: synchronise, debounce, and emit one
// clock-wide pulse per press, optionally followed by auto-repeat pulses.
//   i_clk    system clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      btn_pulser_if.slave: i_button in, o_level/o_pulse/o_repeat out
// Parameters: FREQ (Hz), DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS,
// ACTIVE_LOW (1 = pin reads 0 when pressed).
// Macro BTN_PULSER_REPEAT_EN: when defined, compiles in the REPEAT state and
// repeat counter; otherwise one pulse per press and o_repeat is tied low.
// ---------------------------------------------------------------------------
module btn_pulser
  import btn_pkg::*;
#(
  parameter int FREQ            = 27_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  btn_pulser_if.slave bus
);

  localparam int              DB_CYC  = msToCycles(FREQ, DEBOUNCE_MS);
  localparam int              DB_W    = $clog2(DB_CYC) + 1;
  // A wait state spends exactly DB_CYC cycles counting 0..DB_CYC-1.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

`ifdef BTN_PULSER_REPEAT_EN
  localparam int              RD_CYC  = msToCycles(FREQ, REPEAT_DELAY_MS);
  localparam int              RR_CYC  = msToCycles(FREQ, REPEAT_RATE_MS);
  localparam int              RP_MAX  = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int              RP_W    = $clog2(RP_MAX) + 1;
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(RD_CYC - 1);
  localparam logic [RP_W-1:0] RR_LAST = RP_W'(RR_CYC - 1);
`endif

  logic            pinNorm;
  logic            sBtn;
  logic [2:0]      state_q,  state_d;
  logic [DB_W-1:0] dbCnt_q,  dbCnt_d;
  logic            level_q,  level_d;
  logic            pulse_q,  pulse_d;
`ifdef BTN_PULSER_REPEAT_EN
  logic [RP_W-1:0] rpCnt_q,   rpCnt_d;
  logic            fromRep_q, fromRep_d;
  logic            repeat_q,  repeat_d;
`else
  // Repeat settings are accepted for drop-in compatibility but go nowhere.
  logic [34:0]     unusedRepeatCfg;
  assign unusedRepeatCfg = {32'(REPEAT_DELAY_MS ^ REPEAT_RATE_MS), ST_REPEAT};
`endif

  // Normalise polarity so everything after this point sees 1 = pressed.
  assign pinNorm = (ACTIVE_LOW != 0) ? ~bus.i_button : bus.i_button;

  sync2 #(.RESET_VAL(1'b0)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (pinNorm),
    .o_q    (sBtn)
  );

  // Next-state logic. Wait states count consecutive stable samples and fall
  // back the moment the level disagrees, so bounce always restarts the count.
  // RELEASE_WAIT remembers where it came from so a release glitch resumes
  // the held phase with the repeat counter untouched.
  always_comb begin
    state_d   = state_q;
    dbCnt_d   = dbCnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
`ifdef BTN_PULSER_REPEAT_EN
    rpCnt_d   = rpCnt_q;
    fromRep_d = fromRep_q;
    repeat_d  = repeat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sBtn) begin
          state_d = ST_PRESS_WAIT;
          dbCnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sBtn) begin
          state_d = ST_IDLE;
        end else if (dbCnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
`ifdef BTN_PULSER_REPEAT_EN
          rpCnt_d = '0;
`endif
        end else begin
          dbCnt_d = dbCnt_q + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sBtn) begin
          state_d   = ST_RELEASE_WAIT;
          dbCnt_d   = '0;
`ifdef BTN_PULSER_REPEAT_EN
          fromRep_d = 1'b0;
        end else if (rpCnt_q == RD_LAST) begin
          state_d   = ST_REPEAT;
          pulse_d   = 1'b1;
          repeat_d  = 1'b1;
          rpCnt_d   = '0;
        end else begin
          rpCnt_d   = rpCnt_q + RP_W'(1);
`endif
        end
      end
`ifdef BTN_PULSER_REPEAT_EN
      ST_REPEAT: begin
        if (!sBtn) begin
          state_d   = ST_RELEASE_WAIT;
          dbCnt_d   = '0;
          fromRep_d = 1'b1;
        end else if (rpCnt_q == RR_LAST) begin
          pulse_d   = 1'b1;
          rpCnt_d   = '0;
        end else begin
          rpCnt_d   = rpCnt_q + RP_W'(1);
        end
      end
`endif
      ST_RELEASE_WAIT: begin
        if (sBtn) begin
`ifdef BTN_PULSER_REPEAT_EN
          state_d  = fromRep_q ? ST_REPEAT : ST_PRESSED;
`else
          state_d  = ST_PRESSED;
`endif
        end else if (dbCnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          level_d  = 1'b0;
`ifdef BTN_PULSER_REPEAT_EN
          repeat_d = 1'b0;
`endif
        end else begin
          dbCnt_d  = dbCnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; outputs are registered so o_pulse is a
  // clean single-cycle strobe and nothing toggles while in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      dbCnt_q   <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef BTN_PULSER_REPEAT_EN
      rpCnt_q   <= '0;
      fromRep_q <= 1'b0;
      repeat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dbCnt_q   <= dbCnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
`ifdef BTN_PULSER_REPEAT_EN
      rpCnt_q   <= rpCnt_d;
      fromRep_q <= fromRep_d;
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign bus.o_level  = level_q;
  assign bus.o_pulse  = pulse_q;
`ifdef BTN_PULSER_REPEAT_EN
  assign bus.o_repeat = repeat_q;
`else
  assign bus.o_repeat = 1'b0;
`endif

endmodule
